sprite_loader: RTL and testbench

- Write-side counterpart of the sprite display path. It accepts a raster-ordered pixel stream (valid/ready, start-of-frame marker) and generates write strobes, addresses and data for the 160x120 sprite image RAM.
- The sprite display path reads the same RAM with address = WIDTH*row + col. This block writes with that same mapping, built from counters rather than a multiplier.
- It sits between the image source (UART/SD bridge) and the RAM write port, in the pixel_clk domain.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_loader_if.sv | 24 ++
 rtl/raster_counter.sv | 63 ++++++
 rtl/sprite_loader.sv | 120 ++++++++++++
 tb/tb_sprite_loader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Constants and loader state encoding shared by the sprite loader and the sprite display path.
package sprite_pkg;

  localparam int SPRITE_W      = 160;
  localparam int SPRITE_H      = 120;
  localparam int SPRITE_PIX    = SPRITE_W * SPRITE_H;
  localparam int SPRITE_ADDR_W = 15;
  localparam int PIX_W         = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sprite_loader_if.sv
// Pixel stream in (valid/ready + SOF) and sprite RAM write port out.
interface sprite_loader_if #(
  parameter int ADDR_W = sprite_pkg::SPRITE_ADDR_W,
  parameter int PIX_W  = sprite_pkg::PIX_W
);
  logic              in_valid;
  logic              in_sof;
  logic [PIX_W-1:0]  in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  // master: pixel source plus RAM write sink; slave: the loader itself
  modport master (
    output in_valid, in_sof, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/raster_counter.sv
// Raster col/row/addr counters with clear, increment and last-pixel flag; 0-cycle flag, 1-cycle update.
// Clear and increment together restart the raster and count pixel (0,0) in the same cycle.
module raster_counter #(
  parameter int WIDTH  = sprite_pkg::SPRITE_W,
  parameter int HEIGHT = sprite_pkg::SPRITE_H,
  parameter int ADDR_W = sprite_pkg::SPRITE_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  logic [COL_W-1:0]  r_col, w_col_base, w_col_nxt;
  logic [ROW_W-1:0]  r_row, w_row_base, w_row_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_base, w_addr_nxt;
  logic              w_eol_base, w_last_base;

  always_comb begin
    w_col_base  = i_clr ? '0 : r_col;
    w_row_base  = i_clr ? '0 : r_row;
    w_addr_base = i_clr ? '0 : r_addr;
    w_eol_base  = (w_col_base == COL_W'(WIDTH - 1));
    w_last_base = w_eol_base && (w_row_base == ROW_W'(HEIGHT - 1));
    w_col_nxt   = w_col_base;
    w_row_nxt   = w_row_base;
    w_addr_nxt  = w_addr_base;
    if (i_inc) begin
      // wrap fully after the last pixel so addr stays inside the image
      if (w_last_base) begin
        w_col_nxt  = '0;
        w_row_nxt  = '0;
        w_addr_nxt = '0;
      end else if (w_eol_base) begin
        w_col_nxt  = '0;
        w_row_nxt  = w_row_base + 1'b1;
        w_addr_nxt = w_addr_base + 1'b1;
      end else begin
        w_col_nxt  = w_col_base + 1'b1;
        w_addr_nxt = w_addr_base + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_col == COL_W'(WIDTH - 1)) && (r_row == ROW_W'(HEIGHT - 1));
endmodule

// File: rtl/sprite_loader.sv
// Writes a raster pixel stream into the sprite RAM at WIDTH*row+col; write path 1 cycle, one write per beat.
// in_ready depends on state and abort only; the source is stalled outside SYNC/LOAD.
module sprite_loader #(
  parameter int WIDTH  = sprite_pkg::SPRITE_W,
  parameter int HEIGHT = sprite_pkg::SPRITE_H,
  parameter int ADDR_W = sprite_pkg::SPRITE_ADDR_W,
  parameter int PIX_W  = sprite_pkg::PIX_W
) (
  input  logic            i_pixel_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_abort,
  sprite_loader_if.slave  bus,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sync_err
);
  import sprite_pkg::*;

  loader_state_t     r_state, w_state_nxt;
  logic              w_in_ready, w_beat;
  logic              w_clr, w_inc, w_wr, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              r_wr_en, r_sync_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;

  assign w_in_ready = ((r_state == ST_SYNC) || (r_state == ST_LOAD)) && !i_abort;
  assign w_beat     = w_in_ready && bus.in_valid;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .i_clk  (i_pixel_clk),
    .i_rst  (i_reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = ST_SYNC;
          w_clr       = 1'b1;
        end
      end
      ST_SYNC: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_beat) begin
          if (bus.in_sof) begin
            w_wr        = 1'b1;
            w_clr       = 1'b1;
            w_inc       = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_beat) begin
          w_wr  = 1'b1;
          w_inc = 1'b1;
          // an SOF mid-frame restarts the raster at pixel (0,0)
          if (bus.in_sof) begin
            w_clr = 1'b1;
            w_err = 1'b1;
          end else if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_en    <= 1'b0;
      r_sync_err <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en    <= w_wr;
      r_sync_err <= w_err;
      if (w_wr) begin
        r_wr_addr <= bus.in_sof ? '0 : w_addr;
        r_wr_data <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_busy       = (r_state == ST_SYNC) || (r_state == ST_LOAD);
  assign o_done       = (r_state == ST_DONE);
  assign o_sync_err   = r_sync_err;
endmodule

// File: tb/tb_sprite_loader.sv
// Randomized scoreboard bench for sprite_loader against a raster-position reference model.
module tb_sprite_loader;
  localparam int W = 160;
  localparam int H = 120;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, sync_err;

  always #5 clk = ~clk;

  sprite_loader_if #(.ADDR_W(15), .PIX_W(9)) bus ();

  sprite_loader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(15), .PIX_W(9)) dut (
    .i_pixel_clk (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_abort     (abort),
    .bus         (bus.slave),
    .o_busy      (busy),
    .o_done      (done),
    .o_sync_err  (sync_err)
  );

  typedef struct {
    bit wr;
    bit err;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int last_addr = 0, last_data = 0;
  // reference model: loading = frame in progress, synced = SOF seen, row/col = next raster position
  bit m_loading = 0, m_synced = 0, m_donecyc = 0, m_acc = 0, g_stuck = 0;
  int m_row = 0, m_col = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  // monitor: pops one expectation per presented write or sync error
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_addr = 0;
        last_data = 0;
      end else begin
        if (bus.wr_en || sync_err) begin
          if (q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = q.pop_front();
            chk("wr_en", int'(bus.wr_en), int'(e.wr));
            chk("sync_err", int'(sync_err), int'(e.err));
            chk("done_with_write", int'(done), int'(e.done));
            if (e.wr) begin
              chk("wr_addr", int'(bus.wr_addr), e.addr);
              chk("wr_data", int'(bus.wr_data), e.data);
            end
          end
        end else begin
          chk("done_stray", int'(done), 0);
        end
        if (bus.wr_en) begin
          last_addr = int'(bus.wr_addr);
          last_data = int'(bus.wr_data);
          wr_cnt++;
        end else begin
          chk("wr_addr_hold", int'(bus.wr_addr), last_addr);
          chk("wr_data_hold", int'(bus.wr_data), last_data);
        end
        if (done) done_cnt++;
        if (sync_err) err_cnt++;
      end
    end
  end

  task automatic cycle(input bit v, input bit s, input int d, input bit st, input bit ab);
    bit exp_ready, last, e_err;
    int a;
    @(negedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = 9'(d);
    start        = st;
    abort        = ab;
    #1;
    exp_ready = m_loading && !ab;
    chk("in_ready", int'(bus.in_ready), int'(exp_ready));
    chk("busy", int'(busy), int'(m_loading));
    m_acc = v && exp_ready;
    if (m_donecyc) begin
      m_donecyc = 0;
    end else if (!m_loading) begin
      if (st && !ab) begin
        m_loading = 1;
        m_synced  = 0;
        m_row     = 0;
        m_col     = 0;
      end
    end else if (ab) begin
      m_loading = 0;
    end else if (v) begin
      if (!m_synced && !s) begin
        q.push_back('{1'b0, 1'b1, 0, 0, 1'b0});
      end else begin
        e_err = s && m_synced;
        if (s) begin
          m_row = 0;
          m_col = 0;
        end
        m_synced = 1;
        a    = m_row * W + m_col;
        last = (m_row == H - 1) && (m_col == W - 1);
        q.push_back('{1'b1, e_err, a, d & 511, last});
        if (m_col == W - 1) begin
          m_col = 0;
          m_row++;
        end else begin
          m_col++;
        end
        if (last) begin
          m_loading = 0;
          m_donecyc = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic send(input bit s, input int d, input int pct);
    int tries;
    bit v;
    if (g_stuck) return;
    tries = 0;
    m_acc = 0;
    while (!m_acc && tries < 200) begin
      v = ($urandom_range(99) < pct);
      cycle(v, s, d, 1'b0, 1'b0);
      tries++;
    end
    if (!m_acc) begin
      g_stuck = 1;
      fail_now("beat_timeout");
    end
  endtask

  task automatic frame(input int n, input int pct, input bit rnd);
    for (int i = 0; i < n; i++) send(i == 0, rnd ? int'($urandom_range(511)) : i, pct);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // missing SOF, then a full continuous frame with data = addr[8:0]
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (3) send(1'b0, int'($urandom_range(511)), 100);
    frame(W * H, 100, 1'b0);
    idle(3);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_err_cnt", err_cnt, 3);
    chk("s1_wr_cnt", wr_cnt, W * H);
    chk("s1_last_addr", last_addr, W * H - 1);
    chk("s1_drained", q.size(), 0);

    // random gaps with a mid-frame resync after 500 beats
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(500, 75, 1'b1);
    frame(W * H, 75, 1'b1);
    idle(3);
    chk("s2_done_cnt", done_cnt, 2);
    chk("s2_err_cnt", err_cnt, 4);
    chk("s2_wr_cnt", wr_cnt, 2 * W * H + 500);
    chk("s2_last_addr", last_addr, W * H - 1);
    chk("s2_drained", q.size(), 0);

    // abort at beat 1000, then a clean reload
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(1000, 100, 1'b1);
    cycle(1'b1, 1'b0, 5, 1'b0, 1'b1);
    idle(5);
    chk("s3_abort_done_cnt", done_cnt, 2);
    chk("s3_abort_last_addr", last_addr, 999);
    chk("s3_abort_busy", int'(busy), 0);
    chk("s3_abort_drained", q.size(), 0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(W * H, 100, 1'b1);
    idle(3);
    chk("s3_reload_done_cnt", done_cnt, 3);
    chk("s3_reload_last_addr", last_addr, W * H - 1);

    // async reset between clock edges in the middle of a load
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(300, 100, 1'b1);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    start = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midload_reset");
    chk("midload_reset_queue", q.size(), 0);
    q.delete();
    m_loading = 0;
    m_synced  = 0;
    m_donecyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    idle(2);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(10, 100, 1'b1);
    idle(3);
    chk("s4_last_addr", last_addr, 9);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(3);
    chk("final_drained", q.size(), 0);
    chk("final_done_cnt", done_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
